// File: rtl/testport_write_capture_if.sv
// rtl/testport_write_capture_if.sv - CPU write-bus snoop and checker stream bundle for testport_write_capture
// out_ts exists only when TESTPORT_TIMESTAMP_EN is defined.
interface testport_write_capture_if;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_stall;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        out_last;
`ifdef TESTPORT_TIMESTAMP_EN
    logic [15:0] out_ts;
`endif

    // master: CPU bus plus checker side; slave: the capture block
    modport master (
        output mem_addr, mem_wdata, mem_wen, mem_stall, out_ready,
`ifdef TESTPORT_TIMESTAMP_EN
        input  out_ts,
`endif
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wen, mem_stall, out_ready,
`ifdef TESTPORT_TIMESTAMP_EN
        output out_ts,
`endif
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/testport_write_capture.sv
// rtl/testport_write_capture.sv - captures committed test-port stores between BEGIN/END symbols into a FIFO
// Optional TESTPORT_TIMESTAMP_EN adds per-word out_ts (value of cycles at commit).
module testport_write_capture #(
    parameter logic [29:0] TEST_PORT = 30'h40,
    parameter logic [31:0] BEGIN_SYM = 32'h0000_0932,
    parameter logic [31:0] END_SYM   = 32'h0000_0D5D,
    parameter int          DEPTH     = 8,
    parameter int          AW        = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    testport_write_capture_if.slave     bus,
    output logic                        active,
    output logic                        done,
    output logic                        overflow,
    output logic [7:0]                  drop_cnt,
    output logic [15:0]                 cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        commit;
    logic        is_begin;
    logic        is_end;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        drop;
    logic        empty;
    logic        full;
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic [31:0] head;
    logic [31:0] data_mem [DEPTH];

    // a stalled store only counts on its final unstalled cycle, so held writes commit once
    assign commit   = bus.mem_wen & ~bus.mem_stall & (bus.mem_addr == TEST_PORT);
    assign is_begin = (bus.mem_wdata == BEGIN_SYM);
    assign is_end   = (bus.mem_wdata == END_SYM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        case (state)
            S_IDLE: begin
                if (commit && is_begin) begin
                    state_nxt = S_CAP;
                end
            end
            S_CAP: begin
                push_req = commit;
                // END moves to DONE even if the FIFO has to drop it
                if (commit && is_end) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign empty = (wp == rp);
    assign full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign pop   = ~empty & bus.out_ready;
    // a full FIFO still takes the word when the head leaves in the same cycle
    assign push  = push_req & (~full | pop);
    assign drop  = push_req & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) begin
                wp <= wp + (AW+1)'(1);
            end
            if (pop) begin
                rp <= rp + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wp[AW-1:0]] <= bus.mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
            cycles   <= 16'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
            if ((state == S_CAP) && (cycles != 16'hFFFF)) begin
                cycles <= cycles + 16'd1;
            end
        end
    end

    assign head          = data_mem[rp[AW-1:0]];
    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? 32'd0 : head;
    assign bus.out_last  = ~empty & (head == END_SYM);
    assign active        = (state == S_CAP);
    assign done          = (state == S_DONE) & empty;

`ifdef TESTPORT_TIMESTAMP_EN
    logic [15:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wp[AW-1:0]] <= cycles;
        end
    end

    assign bus.out_ts = empty ? 16'd0 : ts_mem[rp[AW-1:0]];
`endif

endmodule

// File: tb/tb_testport_write_capture.sv
// tb/tb_testport_write_capture.sv - directed self-checking bench for testport_write_capture
module tb_testport_write_capture;

    localparam logic [29:0] TP    = 30'h40;
    localparam logic [31:0] S_BEG = 32'h0000_0932;
    localparam logic [31:0] S_END = 32'h0000_0D5D;

    logic        clk;
    logic        rst;
    logic        active;
    logic        done;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [15:0] cycles;
    int          n_checks;
    int          n_pass;

    testport_write_capture_if bus ();

    testport_write_capture dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .active   (active),
        .done     (done),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .cycles   (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d);
        bus.mem_addr  = TP;
        bus.mem_wdata = d;
        bus.mem_wen   = 1'b1;
        bus.mem_stall = 1'b0;
        tick();
        bus.mem_wen   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wen   = 1'b0;
        bus.mem_stall = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid",    bus.out_valid, 0);
        check("rst_data",     bus.out_data,  0);
        check("rst_last",     bus.out_last,  0);
        check("rst_active",   active,   0);
        check("rst_done",     done,     0);
        check("rst_overflow", overflow, 0);
        check("rst_drop",     drop_cnt, 0);
        check("rst_cycles",   cycles,   0);
        rst = 1'b1;
        tick();

        // T1 framing
        bus.out_ready = 1'b1;
        put(S_BEG);
        check("t1_active", active, 1);
        check("t1_begin_not_pushed", bus.out_valid, 0);
        put(32'd5);
        check("t1_v5", bus.out_valid, 1);
        check("t1_d5", bus.out_data, 5);
        check("t1_l5", bus.out_last, 0);
`ifdef TESTPORT_TIMESTAMP_EN
        check("t1_ts5", bus.out_ts, 0);
`endif
        put(32'd7);
        check("t1_d7", bus.out_data, 7);
        check("t1_l7", bus.out_last, 0);
`ifdef TESTPORT_TIMESTAMP_EN
        check("t1_ts7", bus.out_ts, 1);
`endif
        put(S_END);
        check("t1_dend", bus.out_data, S_END);
        check("t1_lend", bus.out_last, 1);
        check("t1_done_wait", done, 0);
        check("t1_inactive", active, 0);
        tick();
        check("t1_empty", bus.out_valid, 0);
        check("t1_done", done, 1);
        check("t1_cycles", cycles, 3);
        put(32'd11);
        check("t1_done_ignores", bus.out_valid, 0);
        check("t1_cycles_frozen", cycles, 3);

        // T2 stall dedup
        bus.out_ready = 1'b0;
        do_reset();
        put(S_BEG);
        bus.mem_addr  = TP;
        bus.mem_wdata = 32'd42;
        bus.mem_wen   = 1'b1;
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t2_stalled", bus.out_valid, 0);
        bus.mem_stall = 1'b0;
        tick();
        bus.mem_wen   = 1'b0;
        check("t2_valid", bus.out_valid, 1);
        check("t2_data", bus.out_data, 42);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t2_single", bus.out_valid, 0);

        // T3 address and enable filter
        bus.mem_addr  = 30'h41;
        bus.mem_wdata = 32'd9;
        bus.mem_wen   = 1'b1;
        tick();
        bus.mem_addr  = TP;
        bus.mem_wen   = 1'b0;
        tick();
        check("t3_no_push", bus.out_valid, 0);
        check("t3_active", active, 1);

        // T4 overflow
        do_reset();
        put(S_BEG);
        for (int i = 1; i <= 10; i++) put(32'(i));
        check("t4_overflow", overflow, 1);
        check("t4_drop_cnt", drop_cnt, 2);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t4_valid%0d", i), bus.out_valid, 1);
            check($sformatf("t4_data%0d", i), bus.out_data, 32'(i));
            tick();
        end
        check("t4_drained", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // T5 full push with simultaneous pop
        do_reset();
        put(S_BEG);
        for (int i = 1; i <= 8; i++) put(32'(i));
        check("t5_full_nodrop", drop_cnt, 0);
        bus.out_ready = 1'b1;
        put(32'd99);
        for (int i = 2; i <= 8; i++) begin
            check($sformatf("t5_data%0d", i), bus.out_data, 32'(i));
            tick();
        end
        check("t5_data99", bus.out_data, 99);
        tick();
        check("t5_empty", bus.out_valid, 0);
        check("t5_drop", drop_cnt, 0);
        check("t5_overflow", overflow, 0);
        bus.out_ready = 1'b0;

        // T6 reset mid-session
        do_reset();
        put(S_BEG);
        put(32'd1);
        put(32'd2);
        put(32'd3);
        check("t6_queued", bus.out_valid, 1);
        check("t6_cycles_pre", cycles, 3);
        rst = 1'b0;
        #1;
        check("t6_rst_valid", bus.out_valid, 0);
        check("t6_rst_active", active, 0);
        check("t6_rst_cycles", cycles, 0);
        check("t6_rst_data", bus.out_data, 0);
        tick();
        rst = 1'b1;
        tick();
        put(S_END);
        check("t6_idle_end_valid", bus.out_valid, 0);
        check("t6_idle_end_active", active, 0);
        check("t6_idle_end_done", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
